// File: rtl/mem_pkg.sv
// Shared width codes, FSM states and byte-enable lookup
// for the data memory controller.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        W_BYTE,
        W_HALF,
        W_WORD
    } width_t;

    // Any code outside the byte/half set is a word access.
    function automatic width_t decode_width(input logic [2:0] f3);
        width_t w;
        case (f3)
            F3_B, F3_BU: w = W_BYTE;
            F3_H, F3_HU: w = W_HALF;
            default:     w = W_WORD;
        endcase
        return w;
    endfunction

    function automatic logic [1:0] eff_offset(
        input width_t     w,
        input logic [1:0] off
    );
        logic [1:0] o;
        case (w)
            W_BYTE:  o = off;
            W_HALF:  o = {off[1], 1'b0};
            default: o = 2'b00;
        endcase
        return o;
    endfunction

    function automatic logic [3:0] be_lut(
        input width_t     w,
        input logic [1:0] off
    );
        logic [3:0] be;
        case (w)
            W_BYTE:  be = 4'b0001 << off;
            W_HALF:  be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Memory-side request/ack bus between the controller
// (master) and the data memory (slave).
interface data_mem_ctrl_if;

    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output mem_be,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  mem_be,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/store_aligner.sv
// Combinational lane alignment: store byte enables and
// replicated write data, plus the load-data right shift.
module store_aligner
    import mem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    input  logic [1:0]  rd_off_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [1:0]  off_o,
    output logic [31:0] rdata_o
);

    width_t w;

    assign w     = decode_width(funct3_i);
    assign off_o = eff_offset(w, off_i);
    assign be_o  = be_lut(w, off_o);

    // Replicating across lanes lets the byte enables pick the lane.
    always_comb begin
        wdata_o = wdata_i;
        case (w)
            W_BYTE:  wdata_o = {4{wdata_i[7:0]}};
            W_HALF:  wdata_o = {2{wdata_i[15:0]}};
            default: wdata_o = wdata_i;
        endcase
    end

    assign rdata_o = rdata_i >> {rd_off_i, 3'b000};

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: pipeline load/store to a req/ack bus.
// Define MISALIGN_TRAP_EN to reject misaligned half/word accesses.
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            MemReadM,
    input  logic            MemWriteM,
    input  logic [31:0]     ALUOutM,
    input  logic [31:0]     WriteDataM,
    input  logic [2:0]      Funct3M,
    output logic            StallM,
    output logic [31:0]     DataMemOutM,
    output logic            DoneM,
    output logic            ErrM,
    data_mem_ctrl_if.master mem
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [29:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic [1:0]    off_q, off_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          stall;

    logic [3:0]    al_be;
    logic [31:0]   al_wdata;
    logic [31:0]   al_rdata;
    logic [1:0]    al_off;
    logic          trap;

    store_aligner u_align (
        .funct3_i (Funct3M),
        .off_i    (ALUOutM[1:0]),
        .wdata_i  (WriteDataM),
        .rdata_i  (mem.mem_rdata),
        .rd_off_i (off_q),
        .be_o     (al_be),
        .wdata_o  (al_wdata),
        .off_o    (al_off),
        .rdata_o  (al_rdata)
    );

`ifdef MISALIGN_TRAP_EN
    width_t req_w;
    assign req_w = decode_width(Funct3M);

    always_comb begin
        trap = 1'b0;
        case (req_w)
            W_HALF:  trap = ALUOutM[0];
            W_WORD:  trap = |ALUOutM[1:0];
            default: trap = 1'b0;
        endcase
    end
`else
    assign trap = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            off_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            off_q   <= off_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        off_d   = off_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        stall   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (MemReadM && MemWriteM) begin
                    err_d = 1'b1;
                end else if (MemReadM || MemWriteM) begin
                    if (trap) begin
                        err_d = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = BUSY;
                        cnt_d   = '0;
                        we_d    = MemWriteM;
                        addr_d  = ALUOutM[31:2];
                        wdata_d = MemWriteM ? al_wdata : '0;
                        be_d    = MemWriteM ? al_be : 4'hF;
                        off_d   = al_off;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                // A late ack on the final wait cycle still completes.
                if (mem.mem_ack) begin
                    state_d = RESP;
                    if (!we_q) rdata_d = al_rdata;
                end else if (cnt_q == LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign StallM        = stall;
    assign DoneM         = (state_q == RESP);
    assign ErrM          = err_q;
    assign DataMemOutM   = rdata_q;
    assign mem.mem_req   = (state_q == BUSY);
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_be    = be_q;

endmodule
